// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive-side FIFO behind a UART receiver. It stores each frame
//               together with its parity/stop error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 8,
    parameter int DROP_ERRORED = 0
) (
    input  logic                       clk,
    input  logic                       res_n,
    input  logic [DATA_WIDTH-1:0]      rx_data_in,
    input  logic                       rx_valid_in,
    input  logic                       rx_par_err_in,
    input  logic                       rx_stop_err_in,
    input  logic                       rd_ready_in,
    output logic                       rd_valid_out,
    output logic [DATA_WIDTH-1:0]      rd_data_out,
    output logic                       rd_par_err_out,
    output logic                       rd_stop_err_out,
    output logic [$clog2(DEPTH):0]     count_out,
    output logic                       overflow_out,
    output logic [7:0]                 err_cnt_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_WIDTH + 2;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [7:0]    err_cnt;

    logic          full;
    logic          frame_err;
    logic          drop;
    logic          wr_en;
    logic          rd_en;
    logic [EW-1:0] head;

    always_comb begin
        full      = (count == CW'(DEPTH));
        frame_err = rx_par_err_in | rx_stop_err_in;
        drop      = (DROP_ERRORED != 0) && frame_err;
        // A read while full does not make room for this cycle's write.
        wr_en     = rx_valid_in && !full && !drop;
        rd_en     = (count != '0) && rd_ready_in;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {rx_data_in, rx_par_err_in, rx_stop_err_in};
        end
    end

    always_ff @(posedge clk) begin
        if (res_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            err_cnt  <= 8'd0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (rx_valid_in && full) begin
                overflow <= 1'b1;
            end
            if (rx_valid_in && frame_err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        head            = mem[rd_ptr];
        rd_valid_out    = (count != '0);
        rd_data_out     = head[EW-1:2];
        rd_par_err_out  = head[1];
        rd_stop_err_out = head[0];
        count_out       = count;
        overflow_out    = overflow;
        err_cnt_out     = err_cnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// Bench for uart_rx_fifo: a keep-all and a drop-errored instance run side by side
// against a queue-based model, plus directed checks with literal expectations.
module tb_uart_rx_fifo;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       res_n;
    logic [7:0] rx_data;
    logic       rx_valid, rx_par, rx_stop, rd_ready;

    logic       valid_0, par_0, stop_0, ovf_0;
    logic [7:0] data_0, ecnt_0;
    logic [3:0] count_0;
    logic       valid_1, par_1, stop_1, ovf_1;
    logic [7:0] data_1, ecnt_1;
    logic [3:0] count_1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .DROP_ERRORED(0)) u_keep (
        .clk(clk), .res_n(res_n), .rx_data_in(rx_data), .rx_valid_in(rx_valid),
        .rx_par_err_in(rx_par), .rx_stop_err_in(rx_stop), .rd_ready_in(rd_ready),
        .rd_valid_out(valid_0), .rd_data_out(data_0), .rd_par_err_out(par_0),
        .rd_stop_err_out(stop_0), .count_out(count_0), .overflow_out(ovf_0),
        .err_cnt_out(ecnt_0)
    );

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .DROP_ERRORED(1)) u_drop (
        .clk(clk), .res_n(res_n), .rx_data_in(rx_data), .rx_valid_in(rx_valid),
        .rx_par_err_in(rx_par), .rx_stop_err_in(rx_stop), .rd_ready_in(rd_ready),
        .rd_valid_out(valid_1), .rd_data_out(data_1), .rd_par_err_out(par_1),
        .rd_stop_err_out(stop_1), .count_out(count_1), .overflow_out(ovf_1),
        .err_cnt_out(ecnt_1)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       se;
    } entry_t;

    entry_t q0[$];
    entry_t q1[$];
    bit     m_ovf0, m_ovf1;
    int     m_ecnt;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue, the error counter a saturating integer.
    always @(posedge clk) begin
        entry_t e;
        bit     err;
        bit     wr0, wr1;
        e   = '{d: rx_data, pe: rx_par, se: rx_stop};
        err = rx_par || rx_stop;
        if (res_n) begin
            q0.delete();
            q1.delete();
            m_ovf0 = 1'b0;
            m_ovf1 = 1'b0;
            m_ecnt = 0;
        end else begin
            if (rx_valid && q0.size() == DEPTH) m_ovf0 = 1'b1;
            if (rx_valid && q1.size() == DEPTH) m_ovf1 = 1'b1;
            wr0 = rx_valid && (q0.size() < DEPTH);
            wr1 = rx_valid && (q1.size() < DEPTH) && !err;
            if (q0.size() != 0 && rd_ready) void'(q0.pop_front());
            if (q1.size() != 0 && rd_ready) void'(q1.pop_front());
            if (wr0) q0.push_back(e);
            if (wr1) q1.push_back(e);
            if (rx_valid && err && m_ecnt < 255) m_ecnt++;
        end
    end

    always @(negedge clk) begin
        chk("keep.count", int'(count_0), q0.size());
        chk("keep.valid", int'(valid_0), int'(q0.size() != 0));
        chk("keep.overflow", int'(ovf_0), int'(m_ovf0));
        chk("keep.err_cnt", int'(ecnt_0), m_ecnt);
        if (q0.size() != 0) begin
            chk("keep.head", int'({data_0, par_0, stop_0}), int'(q0[0]));
        end
        chk("drop.count", int'(count_1), q1.size());
        chk("drop.valid", int'(valid_1), int'(q1.size() != 0));
        chk("drop.overflow", int'(ovf_1), int'(m_ovf1));
        chk("drop.err_cnt", int'(ecnt_1), m_ecnt);
        if (q1.size() != 0) begin
            chk("drop.head", int'({data_1, par_1, stop_1}), int'(q1[0]));
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic pe,
                       input logic se, input logic rdy);
        rx_valid = v;
        rx_data  = d;
        rx_par   = pe;
        rx_stop  = se;
        rd_ready = rdy;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_par   = 1'b0;
        rx_stop  = 1'b0;
        rd_ready = 1'b0;
    endtask

    task automatic do_reset();
        res_n = 1'b1;
        @(posedge clk);
        #1;
        res_n = 1'b0;
    endtask

    initial begin
        res_n    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rx_par   = 1'b0;
        rx_stop  = 1'b0;
        rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        res_n = 1'b0;

        chk("rst.count", int'(count_0), 0);
        chk("rst.valid", int'(valid_0), 0);
        chk("rst.overflow", int'(ovf_0), 0);
        chk("rst.err_cnt", int'(ecnt_0), 0);

        // Single write, then hold without reading.
        cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("a5.valid", int'(valid_0), 1);
        chk("a5.data", int'(data_0), 8'hA5);
        chk("a5.count", int'(count_0), 1);
        repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("a5.hold_data", int'(data_0), 8'hA5);
        chk("a5.hold_count", int'(count_0), 1);

        // Overfill by one, then drain.
        do_reset();
        for (int i = 1; i <= 9; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        chk("full.count", int'(count_0), 8);
        chk("full.overflow", int'(ovf_0), 1);
        for (int i = 1; i <= 8; i++) begin
            chk("drain.data", int'(data_0), i);
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        chk("drain.valid", int'(valid_0), 0);
        chk("drain.overflow_sticky", int'(ovf_0), 1);

        // Full FIFO: a same-cycle read does not admit the write.
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        chk("fullrw.count", int'(count_0), 7);
        chk("fullrw.head", int'(data_0), 8'h41);

        // Simultaneous write and read with 3 entries.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h13, 1'b0, 1'b0, 1'b1);
        chk("rw.count", int'(count_0), 3);
        for (int i = 1; i <= 3; i++) begin
            chk("rw.order", int'(data_0), 8'h10 + i);
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        chk("rw.empty", int'(valid_0), 0);

        // Parity-errored frame in both modes.
        do_reset();
        cyc(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        chk("perr.keep_count", int'(count_0), 1);
        chk("perr.keep_data", int'(data_0), 8'h3C);
        chk("perr.keep_par", int'(par_0), 1);
        chk("perr.keep_stop", int'(stop_0), 0);
        chk("perr.keep_ecnt", int'(ecnt_0), 1);
        chk("perr.drop_count", int'(count_1), 0);
        chk("perr.drop_ecnt", int'(ecnt_1), 1);

        // Error counter saturation.
        do_reset();
        for (int i = 0; i < 300; i++) cyc(1'b1, 8'(i), 1'b0, 1'b1, 1'b1);
        chk("sat.keep_ecnt", int'(ecnt_0), 255);
        chk("sat.drop_ecnt", int'(ecnt_1), 255);

        // Reset mid-operation with 5 entries and overflow set.
        do_reset();
        for (int i = 1; i <= 9; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("mid.count_before", int'(count_0), 5);
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        rd_ready = 1'b1;
        do_reset();
        rx_valid = 1'b0;
        rd_ready = 1'b0;
        chk("mid.count", int'(count_0), 0);
        chk("mid.valid", int'(valid_0), 0);
        chk("mid.overflow", int'(ovf_0), 0);
        cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        chk("mid.first_data", int'(data_0), 8'h77);
        chk("mid.first_count", int'(count_0), 1);

        // Randomized traffic with varying fill/drain pressure.
        for (int blk = 0; blk < 8; blk++) begin
            int pv, pr;
            pv = $urandom_range(20, 90);
            pr = $urandom_range(20, 90);
            for (int i = 0; i < 500; i++) begin
                res_n    = ($urandom_range(0, 399) == 0);
                rx_valid = ($urandom_range(0, 99) < pv);
                rx_data  = 8'($urandom);
                rx_par   = ($urandom_range(0, 9) == 0);
                rx_stop  = ($urandom_range(0, 9) == 0);
                rd_ready = ($urandom_range(0, 99) < pr);
                @(posedge clk);
                #1;
            end
        end
        res_n    = 1'b0;
        rx_valid = 1'b0;
        rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
